// File: rtl/adc_pkg.sv
`default_nettype none
// ============================================================================
// Package     : adc_pkg
// Description : Shared types and constants for the ADC sample pacer.
//               pacer_state_t : pacer frame sequencer states
//               ADC_DATA_WIDTH: default ADC sample width
//               ADC_OFFSET_BIN: offset-binary zero code for the default width
//               DEFAULT_DIV   : default frame period (500 kHz at 50 MHz)
// Revision    : 1.0 - initial release
// ============================================================================
package adc_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    READ  = 2'd2
  } pacer_state_t;

  localparam int ADC_DATA_WIDTH = 12;
  localparam int ADC_OFFSET_BIN = 2 ** (ADC_DATA_WIDTH - 1);
  localparam int DEFAULT_DIV    = 100;

  // Shortest legal frame period: every slot of the frame plus one idle cycle.
  function automatic int pacer_min_period(input int num_ch);
    return num_ch + 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/pacer_tick_gen.sv
`default_nettype none
// ============================================================================
// Module      : pacer_tick_gen
// Description : Frame-period timebase for the ADC sample pacer. Clamps the
//               requested period to at least NUM_CH+1, latches it on start
//               and at every wrap, and counts 0..P-1 while running.
// Ports       : i_clk   - system clock
//               i_reset - asynchronous active-low reset
//               i_start - latch a fresh period (leaving IDLE)
//               i_run   - counter enable; counter held at 0 when low
//               i_div   - requested frame period in clock cycles
//               o_wrap  - counter is at P-1 this cycle (combinational)
// Revision    : 1.0 - initial release
// ============================================================================
module pacer_tick_gen
  import adc_pkg::*;
#(
  parameter int NUM_CH    = 2,
  parameter int DIV_WIDTH = 16
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_start,
  input  logic                 i_run,
  input  logic [DIV_WIDTH-1:0] i_div,
  output logic                 o_wrap
);

  // Internal width wide enough to hold the clamp floor even for tiny DIV_WIDTH.
  localparam int c_pw = (DIV_WIDTH > 4) ? DIV_WIDTH : 4;
  localparam logic [c_pw-1:0] c_min_period = c_pw'(pacer_min_period(NUM_CH));

  logic [c_pw-1:0] w_div_ext;
  logic [c_pw-1:0] w_period;
  logic [c_pw-1:0] r_period;
  logic [c_pw-1:0] r_count;

  assign w_div_ext = c_pw'(i_div);
  assign w_period  = (w_div_ext < c_min_period) ? c_min_period : w_div_ext;
  assign o_wrap    = i_run && (r_count == (r_period - 1'b1));

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_period <= c_min_period;
      r_count  <= '0;
    end else begin
      // A new period only takes hold at a frame boundary, never mid-frame.
      if (i_start || o_wrap) begin
        r_period <= w_period;
      end
      if (!i_run || o_wrap) begin
        r_count <= '0;
      end else begin
        r_count <= r_count + 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/adc_sample_pacer.sv
`default_nettype none
// ============================================================================
// Module      : adc_sample_pacer
// Description : Drains a show-ahead ADC FIFO one frame (NUM_CH interleaved
//               samples, channel 0 first) every P clock cycles, converts
//               offset binary to two's complement and drives per-channel
//               filter enables. Empty slots replay the channel's last sample
//               and raise o_underrun.
// Macro       : PACER_UNDERRUN_CNT_EN - enables the saturating underrun
//               counter on o_underrun_cnt (tied to 0 otherwise).
// Ports       : i_clk, i_reset (async active-low), i_enable (run level),
//               i_div (frame period), i_fifo_data / i_fifo_empty (FIFO read
//               side), o_fifo_rdreq (pop, combinational), o_data / o_ch /
//               o_valid (sample stream), o_filter_en (per-channel enable),
//               o_underrun (pulse), o_underrun_cnt (optional counter).
// Revision    : 1.0 - initial release
// ============================================================================
module adc_sample_pacer
  import adc_pkg::*;
#(
  parameter int DATA_WIDTH = ADC_DATA_WIDTH,
  parameter int NUM_CH     = 2,
  parameter int DIV_WIDTH  = 16,
  parameter int CNT_WIDTH  = 16,
  localparam int CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                         i_clk,
  input  logic                         i_reset,
  input  logic                         i_enable,
  input  logic [DIV_WIDTH-1:0]         i_div,
  input  logic [DATA_WIDTH-1:0]        i_fifo_data,
  input  logic                         i_fifo_empty,
  output logic                         o_fifo_rdreq,
  output logic signed [DATA_WIDTH-1:0] o_data,
  output logic [CH_W-1:0]              o_ch,
  output logic                         o_valid,
  output logic [NUM_CH-1:0]            o_filter_en,
  output logic                         o_underrun,
  output logic [CNT_WIDTH-1:0]         o_underrun_cnt
);

  // Inverting the MSB converts offset binary to two's complement.
  localparam logic [DATA_WIDTH-1:0] c_offset = {1'b1, {(DATA_WIDTH-1){1'b0}}};

  pacer_state_t                  r_state;
  logic [CH_W-1:0]               r_ch;
  logic signed [DATA_WIDTH-1:0]  r_hold [NUM_CH];
  logic signed [DATA_WIDTH-1:0]  r_data;
  logic [CH_W-1:0]               r_ch_out;
  logic                          r_valid;
  logic [NUM_CH-1:0]             r_filter_en;
  logic                          r_underrun;

  logic                          w_start;
  logic                          w_run;
  logic                          w_wrap;
  logic                          w_slot;
  logic                          w_last;
  logic signed [DATA_WIDTH-1:0]  w_conv;

  assign w_start      = (r_state == IDLE) && i_enable;
  assign w_run        = (r_state != IDLE);
  assign w_slot       = (r_state == READ);
  assign w_last       = (r_ch == CH_W'(NUM_CH - 1));
  assign w_conv       = i_fifo_data ^ c_offset;
  assign o_fifo_rdreq = w_slot && !i_fifo_empty;

  pacer_tick_gen #(
    .NUM_CH    (NUM_CH),
    .DIV_WIDTH (DIV_WIDTH)
  ) u_tick_gen (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_start (w_start),
    .i_run   (w_run),
    .i_div   (i_div),
    .o_wrap  (w_wrap)
  );

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_state     <= IDLE;
      r_ch        <= '0;
      r_data      <= '0;
      r_ch_out    <= '0;
      r_valid     <= 1'b0;
      r_filter_en <= '0;
      r_underrun  <= 1'b0;
      for (int k = 0; k < NUM_CH; k++) begin
        r_hold[k] <= '0;
      end
    end else begin
      r_valid    <= 1'b0;
      r_underrun <= 1'b0;
      case (r_state)
        IDLE: begin
          r_filter_en <= '0;
          if (i_enable) begin
            r_state <= COUNT;
          end
        end
        COUNT: begin
          if (w_wrap) begin
            r_ch    <= '0;
            r_state <= READ;
          end
        end
        READ: begin
          r_valid  <= 1'b1;
          r_ch_out <= r_ch;
          if (!i_fifo_empty) begin
            r_data            <= w_conv;
            r_hold[r_ch]      <= w_conv;
            r_filter_en[r_ch] <= 1'b1;
          end else begin
            // Underrun: replay the channel's last good sample, gate its filter.
            r_data            <= r_hold[r_ch];
            r_filter_en[r_ch] <= 1'b0;
            r_underrun        <= 1'b1;
          end
          // The frame always runs to completion; i_enable is only sampled here.
          if (w_last) begin
            r_state <= i_enable ? COUNT : IDLE;
          end else begin
            r_ch <= r_ch + 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign o_data      = r_data;
  assign o_ch        = r_ch_out;
  assign o_valid     = r_valid;
  assign o_filter_en = r_filter_en;
  assign o_underrun  = r_underrun;

`ifdef PACER_UNDERRUN_CNT_EN
  logic [CNT_WIDTH-1:0] r_underrun_cnt;

  // Counts at the same edge that raises o_underrun, so both move together.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_underrun_cnt <= '0;
    end else if (w_slot && i_fifo_empty && !(&r_underrun_cnt)) begin
      r_underrun_cnt <= r_underrun_cnt + 1'b1;
    end
  end

  assign o_underrun_cnt = r_underrun_cnt;
`else
  assign o_underrun_cnt = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_adc_sample_pacer.sv
`default_nettype none
// ============================================================================
// Module      : tb_adc_sample_pacer
// Description : Randomised self-checking bench for adc_sample_pacer. A
//               show-ahead FIFO is modelled with a queue; expected outputs
//               come from a frame-schedule model (absolute frame start
//               cycles, period latched at each wrap, slots numbered from the
//               frame start).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_adc_sample_pacer;

  localparam int DW   = 12;
  localparam int NCH  = 2;
  localparam int DIVW = 16;
  localparam int CW   = 2;
  localparam int CHW  = 1;
`ifdef PACER_UNDERRUN_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic                 clk    = 1'b0;
  logic                 rst_n  = 1'b1;
  logic                 enable = 1'b0;
  logic [DIVW-1:0]      div    = '0;
  logic [DW-1:0]        fdata  = '0;
  logic                 fempty = 1'b1;
  logic                 rdreq;
  logic signed [DW-1:0] data;
  logic [CHW-1:0]       ch;
  logic                 valid;
  logic [NCH-1:0]       fen;
  logic                 under;
  logic [CW-1:0]        ucnt;

  adc_sample_pacer #(
    .DATA_WIDTH (DW),
    .NUM_CH     (NCH),
    .DIV_WIDTH  (DIVW),
    .CNT_WIDTH  (CW)
  ) dut (
    .i_clk          (clk),
    .i_reset        (rst_n),
    .i_enable       (enable),
    .i_div          (div),
    .i_fifo_data    (fdata),
    .i_fifo_empty   (fempty),
    .o_fifo_rdreq   (rdreq),
    .o_data         (data),
    .o_ch           (ch),
    .o_valid        (valid),
    .o_filter_en    (fen),
    .o_underrun     (under),
    .o_underrun_cnt (ucnt)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int q[$];
  int cyc;
  bit m_active;
  int m_fs, m_p;
  int m_hold [NCH];
  int e_data, e_ch, e_valid, e_fen, e_under, e_cnt;
  int push_pct, en_on_pct, en_off_pct, div_lo, div_hi;
  bit rd_seen;

  task automatic check_value(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", tag, cyc, got, exp);
    end
  endtask

  function automatic int clamp(input int d);
    return (d < NCH + 1) ? NCH + 1 : d;
  endfunction

  task automatic model_reset();
    m_active = 1'b0;
    m_fs = 0;
    m_p = 0;
    e_data = 0; e_ch = 0; e_valid = 0; e_fen = 0; e_under = 0; e_cnt = 0;
    for (int k = 0; k < NCH; k++) m_hold[k] = 0;
  endtask

  task automatic check_outputs();
    check_value("o_data",         int'(data),  e_data);
    check_value("o_ch",           int'(ch),    e_ch);
    check_value("o_valid",        int'(valid), e_valid);
    check_value("o_filter_en",    int'(fen),   e_fen);
    check_value("o_underrun",     int'(under), e_under);
    check_value("o_underrun_cnt", int'(ucnt),  CNT_EN ? e_cnt : 0);
  endtask

  // One cycle of the reference: decides whether this cycle is a frame slot,
  // what the FIFO should see, and what the registered outputs become.
  task automatic model_step();
    int k;
    int exp_rd;
    exp_rd  = 0;
    e_valid = 0;
    e_under = 0;
    if (!m_active) begin
      e_fen = 0;
      if (enable) begin
        m_p      = clamp(int'(div));
        m_fs     = cyc + m_p + 1;
        m_active = 1'b1;
      end
    end else begin
      if (cyc == m_fs - 1) m_p = clamp(int'(div));
      if (cyc >= m_fs && cyc < m_fs + NCH) begin
        k       = cyc - m_fs;
        e_valid = 1;
        e_ch    = k;
        if (q.size() > 0) begin
          exp_rd    = 1;
          e_data    = q[0] - (1 << (DW - 1));
          m_hold[k] = e_data;
          e_fen     = e_fen | (1 << k);
        end else begin
          e_data  = m_hold[k];
          e_fen   = e_fen & ~(1 << k);
          e_under = 1;
          if (e_cnt < (1 << CW) - 1) e_cnt++;
        end
        if (k == NCH - 1) begin
          if (enable) m_fs = m_fs + m_p;
          else        m_active = 1'b0;
        end
      end
    end
    check_value("o_fifo_rdreq", int'(rdreq), exp_rd);
  endtask

  task automatic drive_fifo();
    fempty = (q.size() == 0);
    fdata  = fempty ? DW'($urandom) : DW'(q[0]);
  endtask

  task automatic drive_stimulus();
    if (int'($urandom_range(99)) < push_pct && q.size() < 16)
      q.push_back(int'($urandom_range((1 << DW) - 1)));
    if (enable) begin
      if (int'($urandom_range(99)) < en_off_pct) enable = 1'b0;
    end else if (int'($urandom_range(99)) < en_on_pct) begin
      enable = 1'b1;
    end
    div = DIVW'($urandom_range(div_hi, div_lo));
    drive_fifo();
  endtask

  task automatic run_cycle();
    @(negedge clk);
    check_outputs();
    rd_seen = rdreq;
    model_step();
    @(posedge clk);
    #1;
    if (rd_seen && q.size() > 0) void'(q.pop_front());
    cyc++;
    drive_stimulus();
  endtask

  // Asynchronous reset landing inside a frame: outputs must clear without a clock.
  task automatic reset_mid_frame();
    rst_n = 1'b0;
    #2;
    model_reset();
    check_outputs();
    check_value("o_fifo_rdreq_in_reset", int'(rdreq), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc++;
    drive_stimulus();
  endtask

  task automatic set_mode(input int push, input int on, input int off,
                          input int lo, input int hi);
    push_pct = push; en_on_pct = on; en_off_pct = off; div_lo = lo; div_hi = hi;
  endtask

  initial begin
    model_reset();
    cyc = 0;
    set_mode(0, 0, 0, 0, 0);
    #1 rst_n = 1'b0;
    drive_fifo();
    repeat (3) @(posedge clk);
    #1;
    check_outputs();
    check_value("o_fifo_rdreq_reset", int'(rdreq), 0);
    rst_n = 1'b1;

    // Known conversion words at a 100-cycle period, then the FIFO runs dry.
    q.push_back(12'h800); q.push_back(12'hFFF); q.push_back(12'h000);
    q.push_back(12'h900); q.push_back(12'h700); q.push_back(12'hA00);
    set_mode(0, 100, 0, 100, 100);
    drive_stimulus();
    repeat (520) run_cycle();

    // Period change 100 -> 50 arriving part-way through a frame.
    for (int i = 0; i < 8; i++) q.push_back(int'($urandom_range(4095)));
    repeat (150) run_cycle();
    set_mode(0, 100, 0, 50, 50);
    repeat (220) run_cycle();

    // Clamp: requested periods below NUM_CH+1.
    set_mode(60, 100, 0, 0, 1);
    repeat (80) run_cycle();

    // Enable dropped during slot 0: the frame completes, then IDLE.
    set_mode(0, 0, 0, 8, 8);
    for (int i = 0; i < 6; i++) q.push_back(int'($urandom_range(4095)));
    for (int i = 0; i < 40; i++) begin
      run_cycle();
      if (m_active && cyc == m_fs && enable) enable = 1'b0;
    end
    repeat (20) run_cycle();

    // Random traffic with occasional asynchronous resets inside a frame.
    set_mode(45, 20, 5, 0, 12);
    for (int i = 0; i < 3000; i++) begin
      run_cycle();
      if (m_active && cyc >= m_fs && cyc < m_fs + NCH && $urandom_range(99) < 3)
        reset_mid_frame();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
